// File: rtl/ili_fill_rect.sv
// ILI9341 rectangle fill: emits CASET/PASET/RAMWR with arguments, then one RGB565 word per pixel.
// Optional ILI_FILL_CLAMP_EN clamps x1/y1 to the panel edge instead of rejecting the request.
module ili_fill_rect #(
   parameter int H_RES   = 240,
   parameter int V_RES   = 320,
   parameter int COORD_W = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [COORD_W-1:0] i_x0,
   input  logic [COORD_W-1:0] i_x1,
   input  logic [COORD_W-1:0] i_y0,
   input  logic [COORD_W-1:0] i_y1,
   input  logic [15:0]        i_color,
   input  logic               i_byte_done,
   output logic               o_send,
   output logic [7:0]         o_data,
   output logic               o_dc,
   output logic               o_cs,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CHECK  = 3'd1;
   localparam logic [2:0] S_CMD    = 3'd2;
   localparam logic [2:0] S_ARG    = 3'd3;
   localparam logic [2:0] S_PIX_HI = 3'd4;
   localparam logic [2:0] S_PIX_LO = 3'd5;
   localparam logic [2:0] S_WAIT   = 3'd6;
   localparam logic [2:0] S_FINISH = 3'd7;

   localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(V_RES - 1);
   localparam logic [3:0]         HDR_LEN = 4'd11;

   logic [2:0]         state;
   logic [COORD_W-1:0] x0, x1, y0, y1;
   logic [15:0]        color;
   logic [3:0]         hdr_idx;
   logic [16:0]        pix_cnt;
   logic               hi_sent;

   logic [COORD_W-1:0] x1_eff, y1_eff;
   logic               req_bad;
   logic [16:0]        width_px, height_px, pix_total;
   logic [15:0]        x0_w, x1_w, y0_w, y1_w;
   logic [7:0]         hdr_data;
   logic               hdr_dc;

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      x1_eff = x1;
      y1_eff = y1;
`ifdef ILI_FILL_CLAMP_EN
      if (x1 > X_MAX) x1_eff = X_MAX;
      if (y1 > Y_MAX) y1_eff = Y_MAX;
      req_bad = (x0 > x1_eff) || (y0 > y1_eff);
`else
      req_bad = (x0 > x1) || (y0 > y1) || (x1 > X_MAX) || (y1 > Y_MAX);
`endif
      width_px  = 17'(x1_eff) - 17'(x0) + 17'd1;
      height_px = 17'(y1_eff) - 17'(y0) + 17'd1;
      pix_total = width_px * height_px;
   end

   assign x0_w = 16'(x0);
   assign x1_w = 16'(x1);
   assign y0_w = 16'(y0);
   assign y1_w = 16'(y1);

   // Header byte hdr_idx of the command preamble; index 0 (0x2A) is issued straight from CHECK.
   always_comb begin
      hdr_data = 8'h00;
      hdr_dc   = 1'b1;
      case (hdr_idx)
         4'd0:    begin hdr_data = 8'h2A; hdr_dc = 1'b0; end
         4'd1:    hdr_data = x0_w[15:8];
         4'd2:    hdr_data = x0_w[7:0];
         4'd3:    hdr_data = x1_w[15:8];
         4'd4:    hdr_data = x1_w[7:0];
         4'd5:    begin hdr_data = 8'h2B; hdr_dc = 1'b0; end
         4'd6:    hdr_data = y0_w[15:8];
         4'd7:    hdr_data = y0_w[7:0];
         4'd8:    hdr_data = y1_w[15:8];
         4'd9:    hdr_data = y1_w[7:0];
         4'd10:   begin hdr_data = 8'h2C; hdr_dc = 1'b0; end
         default: begin hdr_data = 8'h00; hdr_dc = 1'b1; end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_IDLE;
         x0      <= '0;
         x1      <= '0;
         y0      <= '0;
         y1      <= '0;
         color   <= '0;
         hdr_idx <= '0;
         pix_cnt <= '0;
         hi_sent <= 1'b0;
         o_send  <= 1'b0;
         o_data  <= 8'h00;
         o_dc    <= 1'b0;
         o_cs    <= 1'b1;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         o_send <= 1'b0;
         o_done <= 1'b0;
         o_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  x0     <= i_x0;
                  x1     <= i_x1;
                  y0     <= i_y0;
                  y1     <= i_y1;
                  color  <= i_color;
                  o_busy <= 1'b1;
                  state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (req_bad) begin
                  o_err  <= 1'b1;
                  o_busy <= 1'b0;
                  state  <= S_IDLE;
               end else begin
                  x1      <= x1_eff;
                  y1      <= y1_eff;
                  pix_cnt <= pix_total;
                  hdr_idx <= 4'd1;
                  hi_sent <= 1'b0;
                  o_send  <= 1'b1;
                  o_data  <= 8'h2A;
                  o_dc    <= 1'b0;
                  o_cs    <= 1'b0;
                  state   <= S_CMD;
               end
            end
            S_CMD, S_ARG, S_PIX_HI, S_PIX_LO: state <= S_WAIT;
            S_WAIT: begin
               if (i_byte_done) begin
                  if (hdr_idx != HDR_LEN) begin
                     o_send  <= 1'b1;
                     o_data  <= hdr_data;
                     o_dc    <= hdr_dc;
                     hdr_idx <= hdr_idx + 4'd1;
                     state   <= hdr_dc ? S_ARG : S_CMD;
                  end else if (hi_sent) begin
                     o_send  <= 1'b1;
                     o_data  <= color[7:0];
                     o_dc    <= 1'b1;
                     hi_sent <= 1'b0;
                     state   <= S_PIX_LO;
                  end else if (pix_cnt != 17'd0) begin
                     o_send  <= 1'b1;
                     o_data  <= color[15:8];
                     o_dc    <= 1'b1;
                     hi_sent <= 1'b1;
                     pix_cnt <= pix_cnt - 17'd1;
                     state   <= S_PIX_HI;
                  end else begin
                     o_cs   <= 1'b1;
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                     state  <= S_FINISH;
                  end
               end
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ili_fill_rect.sv
// Directed bench for ili_fill_rect: byte/dc streams, handshake latency, cs framing, errors, reset abort.
module tb_ili_fill_rect;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_start = 1'b0;
   logic [8:0]  i_x0 = '0, i_x1 = '0, i_y0 = '0, i_y1 = '0;
   logic [15:0] i_color = '0;
   logic        i_byte_done = 1'b0;
   logic        o_send, o_dc, o_cs, o_busy, o_done, o_err;
   logic [7:0]  o_data;

   ili_fill_rect dut (
      .clk(clk), .rst(rst), .i_start(i_start),
      .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1), .i_color(i_color),
      .i_byte_done(i_byte_done),
      .o_send(o_send), .o_data(o_data), .o_dc(o_dc), .o_cs(o_cs),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];
   bit got_done, got_err, cs_low_seen, aborted;
   int err_cyc, first_send_cyc, cs_bad, lat_bad, hold_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_send"}, 32'(o_send), 32'd0);
      check({tag, "_data"}, 32'(o_data), 32'h00);
      check({tag, "_dc"},   32'(o_dc),   32'd0);
      check({tag, "_cs"},   32'(o_cs),   32'd1);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_done"}, 32'(o_done), 32'd0);
      check({tag, "_err"},  32'(o_err),  32'd0);
   endtask

   function automatic void build_exp(input logic [8:0] x0, x1, y0, y1, input logic [15:0] c, input int n);
      exp_q.delete();
      exp_q.push_back({1'b0, 8'h2A});
      exp_q.push_back({1'b1, 7'd0, x0[8]}); exp_q.push_back({1'b1, x0[7:0]});
      exp_q.push_back({1'b1, 7'd0, x1[8]}); exp_q.push_back({1'b1, x1[7:0]});
      exp_q.push_back({1'b0, 8'h2B});
      exp_q.push_back({1'b1, 7'd0, y0[8]}); exp_q.push_back({1'b1, y0[7:0]});
      exp_q.push_back({1'b1, 7'd0, y1[8]}); exp_q.push_back({1'b1, y1[7:0]});
      exp_q.push_back({1'b0, 8'h2C});
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({1'b1, c[15:8]});
         exp_q.push_back({1'b1, c[7:0]});
      end
   endfunction

   task automatic compare_stream(input string tag);
      int first_bad = exp_q.size();
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i] && first_bad == exp_q.size()) first_bad = i;
      check({tag, "_first_bad_idx"}, 32'(first_bad), 32'(exp_q.size()));
   endtask

   // Drives one request and acts as the spi_ctrl responder; stops on done, err, abort or budget.
   task automatic run_fill(input logic [8:0] x0, x1, y0, y1, input logic [15:0] col,
                           input int max_dly, input bit poke, input int abort_at);
      int  wait_left = 0;
      bit  bd_prev = 0;
      bit  started = 0;
      logic [8:0] prev = '0;
      got_q.delete();
      got_done = 0; got_err = 0; cs_low_seen = 0; aborted = 0;
      err_cyc = -1; first_send_cyc = -1; cs_bad = 0; lat_bad = 0; hold_bad = 0;
      @(posedge clk); #1;
      i_x0 = x0; i_x1 = x1; i_y0 = y0; i_y1 = y1; i_color = col; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      check("busy_t1", 32'(o_busy), 32'd1);
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(posedge clk); #1;
         i_byte_done = 1'b0;
         i_start = 1'b0;
         if (bd_prev && !(o_send || o_done)) lat_bad++;
         bd_prev = 0;
         if (!o_cs) cs_low_seen = 1;
         if (o_err) begin got_err = 1; err_cyc = cyc; break; end
         if (o_done) begin
            got_done = 1;
            if (o_cs !== 1'b1 || o_busy !== 1'b0) cs_bad++;
            break;
         end
         if (started && o_cs) cs_bad++;
         if (o_send) begin
            if (!started) first_send_cyc = cyc;
            started = 1;
            if (o_cs) cs_bad++;
            got_q.push_back({o_dc, o_data});
            prev = {o_dc, o_data};
            wait_left = $urandom_range(max_dly, 1);
            if (abort_at > 0 && got_q.size() == abort_at) begin
               rst = 1'b0; aborted = 1; break;
            end
         end else begin
            if (started && {o_dc, o_data} !== prev) hold_bad++;
            if (wait_left > 0) begin
               wait_left--;
               if (wait_left == 0) begin i_byte_done = 1'b1; bd_prev = 1; end
            end
         end
         if (poke && $urandom_range(2, 0) == 0) begin
            i_start = 1'b1; i_x0 = 9'd0; i_x1 = 9'd200; i_color = 16'h5555;
         end
      end
      i_start = 1'b0;
      i_byte_done = 1'b0;
   endtask

   task automatic check_good_fill(input string tag);
      check({tag, "_done"},       32'(got_done), 32'd1);
      check({tag, "_first_t2"},   32'(first_send_cyc), 32'd0);
      check({tag, "_cs_frame"},   32'(cs_bad), 32'd0);
      check({tag, "_latency"},    32'(lat_bad), 32'd0);
      check({tag, "_hold"},       32'(hold_bad), 32'd0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
      check({tag, "_idle_busy"},  32'(o_busy), 32'd0);
      check({tag, "_idle_cs"},    32'(o_cs),   32'd1);
   endtask

   task automatic check_err_fill(input string tag);
      check({tag, "_err_t2"},   32'(err_cyc), 32'd0);
      check({tag, "_no_send"},  32'(got_q.size()), 32'd0);
      check({tag, "_no_cs"},    32'(cs_low_seen), 32'd0);
      @(posedge clk); #1;
      check({tag, "_busy_t3"},  32'(o_busy), 32'd0);
      check({tag, "_err_pulse"}, 32'(o_err), 32'd0);
   endtask

   initial begin
      logic [7:0]  lit1 [15] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2B, 8'h00, 8'h00,
                                 8'h00, 8'h00, 8'h2C, 8'hF8, 8'h00, 8'hF8, 8'h00};
      logic [14:0] dc1 = 15'b011110111101111;
      logic [7:0]  lit2 [13] = '{8'h2A, 8'h00, 8'hEF, 8'h00, 8'hEF, 8'h2B, 8'h01, 8'h3F,
                                 8'h01, 8'h3F, 8'h2C, 8'h07, 8'hE0};
      logic [12:0] dc2 = 13'b0111101111011;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst = 1'b1;

      // Two-pixel row, hand-written stream and dc pattern.
      exp_q.delete();
      for (int i = 0; i < 15; i++) exp_q.push_back({dc1[14-i], lit1[i]});
      run_fill(9'd0, 9'd1, 9'd0, 9'd0, 16'hF800, 1, 0, 0);
      compare_stream("rect2");
      check_good_fill("rect2");

      // Bottom-right corner pixel.
      exp_q.delete();
      for (int i = 0; i < 13; i++) exp_q.push_back({dc2[12-i], lit2[i]});
      run_fill(9'd239, 9'd239, 9'd319, 9'd319, 16'h07E0, 3, 0, 0);
      compare_stream("corner");
      check_good_fill("corner");

      run_fill(9'd10, 9'd5, 9'd0, 9'd0, 16'h1111, 1, 0, 0);
      check_err_fill("x_swap");

      run_fill(9'd0, 9'd0, 9'd7, 9'd2, 16'h2222, 1, 0, 0);
      check_err_fill("y_swap");

`ifdef ILI_FILL_CLAMP_EN
      build_exp(9'd0, 9'd239, 9'd0, 9'd0, 16'h001F, 240);
      run_fill(9'd0, 9'd300, 9'd0, 9'd0, 16'h001F, 1, 0, 0);
      compare_stream("clamp_x");
      check_good_fill("clamp_x");
`else
      run_fill(9'd0, 9'd300, 9'd0, 9'd0, 16'h001F, 1, 0, 0);
      check_err_fill("range_x");
      run_fill(9'd0, 9'd0, 9'd0, 9'd320, 16'h001F, 1, 0, 0);
      check_err_fill("range_y");
`endif

      // Reset right after the 5th pixel byte (16th byte overall) is sent.
      run_fill(9'd0, 9'd3, 9'd0, 9'd0, 16'hA5A5, 2, 0, 16);
      check("abort_hit", 32'(aborted), 32'd1);
      @(posedge clk); #1;
      check_reset_vals("abort");
      rst = 1'b1;
      build_exp(9'd0, 9'd1, 9'd0, 9'd1, 16'h1234, 4);
      run_fill(9'd0, 9'd1, 9'd0, 9'd1, 16'h1234, 2, 0, 0);
      compare_stream("restart");
      check_good_fill("restart");

      // Random 1-20 cycle responder with i_start poked while busy.
      build_exp(9'd2, 9'd4, 9'd3, 9'd5, 16'hABCD, 9);
      run_fill(9'd2, 9'd4, 9'd3, 9'd5, 16'hABCD, 20, 1, 0);
      compare_stream("rand_dly");
      check_good_fill("rand_dly");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ili_fill_rect.md
# ili_fill_rect

Rectangle-fill engine for the ILI9341 panel, sitting directly upstream of the SPI byte shifter (spi_ctrl/spi_shift pair) in place of the command-array sender once initialisation is done. On a start request it emits, byte by byte, the column-address (0x2A), page-address (0x2B) and memory-write (0x2C) commands with their arguments, then streams one 16-bit RGB565 colour for every pixel in the rectangle. It drives the panel's dc and cs lines and reports busy/done/error to the display controller.

## Interface
- H_RES, 240, panel width in pixels
- V_RES, 320, panel height in pixels
- COORD_W, 9, coordinate width in bits
- clk  in  1  system clock (the divided SPI-domain clock)
- rst  in  1  synchronous reset, active-low
- i_start  in  1  one-cycle fill request, sampled only in IDLE
- i_x0, i_x1  in  COORD_W  column range, inclusive
- i_y0, i_y1  in  COORD_W  page range, inclusive
- i_color  in  16  RGB565 fill colour
- i_byte_done  in  1  one-cycle pulse from spi_ctrl when a byte has been shifted
- o_send  out  1  one-cycle pulse requesting transmission of o_data
- o_data  out  8  byte to shift, MSB first
- o_dc  out  1  0 = command byte, 1 = data byte
- o_cs  out  1  panel chip select, active-low
- o_busy  out  1  high from the cycle after the accepted i_start until o_done
- o_done  out  1  one-cycle pulse on completion
- o_err  out  1  one-cycle pulse on a rejected request

## Operation
- States: IDLE, CHECK, CMD, ARG, PIX_HI, PIX_LO, WAIT, FINISH.
- IDLE: on i_start, register coords and colour, then go to CHECK. i_start is ignored in every other state.
- CHECK: the request is invalid if x0>x1, y0>y1, x1>=H_RES or y1>=V_RES. An invalid request pulses o_err and returns to IDLE without asserting o_cs or o_send.
- Byte order: 2A(dc0), x0[15:8], x0[7:0], x1[15:8], x1[7:0](dc1), 2B(dc0), y0H, y0L, y1H, y1L(dc1), 2C(dc0), then colour[15:8], colour[7:0] repeated N times (dc1).
- N = (x1-x0+1)*(y1-y0+1). Pixel counter is 17 bits and counts down from N to 0. Coordinates are zero-extended to 16 bits.
- After each o_send, go to WAIT. WAIT holds o_data and o_dc stable until i_byte_done, then advances to the next byte state.
- FINISH: entered on the i_byte_done of the final colour byte.
- Reset (rst=0 at a clock edge), including mid-stream: state goes to IDLE, counters clear, and outputs take their reset values on that edge. Any partial stream is abandoned.

## Timing
- Reset values: o_send=0, o_data=0x00, o_dc=0, o_cs=1, o_busy=0, o_done=0, o_err=0.
- i_start in cycle T:
  - o_busy=1 in T+1 (CHECK).
  - First o_send in T+2, with o_cs falling in the same cycle.
  - o_err, if the request is invalid, pulses in T+2.
- i_byte_done in cycle U: the next o_send is in U+1. o_dc changes only in the cycle o_send is asserted.
- o_cs stays low continuously from the first o_send to FINISH.
- FINISH is the cycle after the last i_byte_done. In FINISH: o_cs=1, o_done=1, o_busy=0. IDLE follows.
- i_byte_done received outside WAIT is ignored.
- Total bytes per fill = 11 + 2N.

## Configuration
- ILI_FILL_CLAMP_EN:
  - Defined: x1 and y1 beyond the panel are clamped to H_RES-1 and V_RES-1 in CHECK, and the fill proceeds. x0>x1 or y0>y1, evaluated after clamping, still triggers o_err.
  - Undefined: out-of-range x1 or y1 triggers o_err.

## Test plan
- Rect (0,0)-(1,0), colour 0xF800:
  - Byte stream is 2A 00 00 00 01 2B 00 00 00 00 2C F8 00 F8 00 (15 bytes).
  - dc pattern is 0,1111,0,1111,0,1111.
  - o_done one cycle after the 15th i_byte_done; o_cs low throughout.
- Single pixel (239,319), colour 0x07E0:
  - Stream is 2A 00 EF 00 EF 2B 01 3F 01 3F 2C 07 E0; o_done follows.
- x0=10, x1=5: o_err pulses at T+2; o_send and o_cs never assert; o_busy low by T+3.
- x1=300, y=(0,0), colour 0x001F:
  - With ILI_FILL_CLAMP_EN, the x1 bytes are 00 EF and 240 pixels follow (491 bytes total).
  - Without the macro, o_err pulses.
- Reset after the 5th pixel byte: outputs return to reset values on the next edge. A new request afterwards restarts from 0x2A.
- i_start pulsed while busy and during WAIT: ignored, and the stream is unchanged. A responder with random 1–20 cycle i_byte_done delay yields an identical byte sequence.
